// File: rtl/rgb_xyz_pkg.sv
// ============================================================================
// Module   : rgb_xyz_pkg
// Purpose  : Fixed-point constants and coefficient type for the RGB->XYZ pipe.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rgb_xyz_pkg;

  localparam int FRAC_W  = 12;
  localparam int ROUND_C = 2048;

  typedef logic [FRAC_W-1:0] coef_t;

  // Unsigned Q0.12 matrix rows X, Y, Z
  localparam coef_t C_XR = 12'd1679;
  localparam coef_t C_XG = 12'd1475;
  localparam coef_t C_XB = 12'd737;
  localparam coef_t C_YR = 12'd860;
  localparam coef_t C_YG = 12'd2908;
  localparam coef_t C_YB = 12'd295;
  localparam coef_t C_ZR = 12'd78;
  localparam coef_t C_ZG = 12'd492;
  localparam coef_t C_ZB = 12'd3891;

endpackage

`default_nettype wire

// File: rtl/rgb_xyz_pipe_if.sv
// ============================================================================
// Module   : rgb_xyz_pipe_if
// Purpose  : Pixel-in / XYZ-out valid-ready bundle for rgb_xyz_pipe.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface rgb_xyz_pipe_if #(
  parameter int PIX_W = 8,
  parameter int LANES = 1,
  parameter int OUT_W = PIX_W + 1
);

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*PIX_W-1:0] R_in;
  logic [LANES*PIX_W-1:0] G_in;
  logic [LANES*PIX_W-1:0] B_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] X_out;
  logic [LANES*OUT_W-1:0] Y_out;
  logic [LANES*OUT_W-1:0] Z_out;

  modport master (
    output in_valid, R_in, G_in, B_in, out_ready,
    input  in_ready, out_valid, X_out, Y_out, Z_out
  );

  modport slave (
    input  in_valid, R_in, G_in, B_in, out_ready,
    output in_ready, out_valid, X_out, Y_out, Z_out
  );

endinterface

`default_nettype wire

// File: rtl/rgb_xyz_lane.sv
// ============================================================================
// Module   : rgb_xyz_lane
// Purpose  : One pixel lane: registered products, then sum/round(/clamp).
//            Clamp to 2^PIX_W-1 is built when RGB_XYZ_CLAMP_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_xyz_lane
  import rgb_xyz_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int OUT_W = PIX_W + 1
) (
  input  wire logic             Clk,
  input  wire logic             Reset_n,
  input  wire logic             en,
  input  wire logic [PIX_W-1:0] r_in,
  input  wire logic [PIX_W-1:0] g_in,
  input  wire logic [PIX_W-1:0] b_in,
  output logic      [OUT_W-1:0] x_out,
  output logic      [OUT_W-1:0] y_out,
  output logic      [OUT_W-1:0] z_out
);

  localparam int PROD_W = PIX_W + FRAC_W;
  localparam int SUM_W  = PIX_W + 14;
  localparam int RND_W  = SUM_W - FRAC_W;

  localparam coef_t COEF [3][3] = '{'{C_XR, C_XG, C_XB},
                                    '{C_YR, C_YG, C_YB},
                                    '{C_ZR, C_ZG, C_ZB}};

`ifdef RGB_XYZ_CLAMP_EN
  localparam logic [RND_W-1:0] MAX_PIX = RND_W'((1 << PIX_W) - 1);
`endif

  logic [PIX_W-1:0]  comp [3];
  logic [PROD_W-1:0] prod_d [3][3];
  logic [PROD_W-1:0] prod_q [3][3];
  logic [OUT_W-1:0]  res_d [3];
  logic [OUT_W-1:0]  res_q [3];
  logic [SUM_W-1:0]  sum;
  logic [RND_W-1:0]  rnd;

  assign comp[0] = r_in;
  assign comp[1] = g_in;
  assign comp[2] = b_in;

  always_comb begin
    sum = '0;
    rnd = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        prod_d[i][j] = en ? PROD_W'(COEF[i][j]) * PROD_W'(comp[j]) : prod_q[i][j];
      end
      // round-half-up: add half an LSB of the Q0.12 result before dropping fraction
      sum = SUM_W'(prod_q[i][0]) + SUM_W'(prod_q[i][1]) + SUM_W'(prod_q[i][2])
          + SUM_W'(ROUND_C);
      rnd = RND_W'(sum >> FRAC_W);
`ifdef RGB_XYZ_CLAMP_EN
      if (rnd > MAX_PIX) rnd = MAX_PIX;
`endif
      res_d[i] = en ? OUT_W'(rnd) : res_q[i];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 3; i++) begin
        res_q[i] <= '0;
        for (int j = 0; j < 3; j++) prod_q[i][j] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        res_q[i] <= res_d[i];
        for (int j = 0; j < 3; j++) prod_q[i][j] <= prod_d[i][j];
      end
    end
  end

  assign x_out = res_q[0];
  assign y_out = res_q[1];
  assign z_out = res_q[2];

endmodule

`default_nettype wire

// File: rtl/rgb_xyz_pipe.sv
// ============================================================================
// Module   : rgb_xyz_pipe
// Purpose  : 3-stage RGB->XYZ converter, LANES pixels/beat, whole-pipe stall.
//            Optional output clamp selected by RGB_XYZ_CLAMP_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_xyz_pipe
  import rgb_xyz_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int LANES = 1,
  parameter int OUT_W = PIX_W + 1
) (
  input  wire logic     Clk,
  input  wire logic     Reset_n,
  rgb_xyz_pipe_if.slave bus
);

  logic                   en;
  logic                   v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic [LANES*PIX_W-1:0] r_d, r_q, g_d, g_q, b_d, b_q;
  logic [LANES*OUT_W-1:0] x_w, y_w, z_w;

  // Every stage moves together; a full output stage blocks the whole pipe
  assign en           = !v3_q || bus.out_ready;
  assign bus.in_ready = en;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    r_d  = r_q;
    g_d  = g_q;
    b_d  = b_q;
    if (en) begin
      v1_d = bus.in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
      r_d  = bus.R_in;
      g_d  = bus.G_in;
      b_d  = bus.B_in;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    rgb_xyz_lane #(
      .PIX_W (PIX_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .en      (en),
      .r_in    (r_q[k*PIX_W +: PIX_W]),
      .g_in    (g_q[k*PIX_W +: PIX_W]),
      .b_in    (b_q[k*PIX_W +: PIX_W]),
      .x_out   (x_w[k*OUT_W +: OUT_W]),
      .y_out   (y_w[k*OUT_W +: OUT_W]),
      .z_out   (z_w[k*OUT_W +: OUT_W])
    );
  end

  assign bus.out_valid = v3_q;
  assign bus.X_out     = x_w;
  assign bus.Y_out     = y_w;
  assign bus.Z_out     = z_w;

endmodule

`default_nettype wire

// File: tb/tb_rgb_xyz_pipe.sv
// ============================================================================
// Module   : tb_rgb_xyz_pipe
// Purpose  : Directed self-checking bench for rgb_xyz_pipe with two lanes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rgb_xyz_pipe;

  localparam int PIX_W = 8;
  localparam int LANES = 2;
  localparam int OUT_W = 9;
`ifdef RGB_XYZ_CLAMP_EN
  localparam int Z_WHITE = 255;
`else
  localparam int Z_WHITE = 278;
`endif

  typedef struct { int r; int g; int b; int x; int y; int z; } vec_t;
  typedef struct { int i0; int i1; } exp_t;

  logic clk;
  logic Reset_n;
  rgb_xyz_pipe_if #(.PIX_W(PIX_W), .LANES(LANES), .OUT_W(OUT_W)) bus ();

  rgb_xyz_pipe #(.PIX_W(PIX_W), .LANES(LANES), .OUT_W(OUT_W)) dut (
    .Clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t tbl [7];
  exp_t expq [$];
  int   nchecks = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   cur0 = 0;
  int   cur1 = 0;
  int   nout = 0;
  int   first_out = -1;
  int   last_out = -1;
  logic acc, last_ov, rdy_seen, prev_stall;
  int   prev_x;

  task automatic chk(input string tag, input int obs, input int exp_v);
    nchecks++;
    if (obs != exp_v) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic set_pix(input int i0, input int i1);
    cur0 = i0;
    cur1 = i1;
    bus.R_in = {8'(tbl[i1].r), 8'(tbl[i0].r)};
    bus.G_in = {8'(tbl[i1].g), 8'(tbl[i0].g)};
    bus.B_in = {8'(tbl[i1].b), 8'(tbl[i0].b)};
  endtask

  // One clock: observe at negedge (accept, output, stall behaviour), resume after posedge
  task automatic step();
    exp_t e;
    @(negedge clk);
    acc      = bus.in_valid && bus.in_ready;
    rdy_seen = bus.in_ready;
    last_ov  = bus.out_valid;
    if (acc) expq.push_back('{cur0, cur1});
    if (bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("x_lane0", int'(bus.X_out[8:0]),  tbl[e.i0].x);
        chk("y_lane0", int'(bus.Y_out[8:0]),  tbl[e.i0].y);
        chk("z_lane0", int'(bus.Z_out[8:0]),  tbl[e.i0].z);
        chk("x_lane1", int'(bus.X_out[17:9]), tbl[e.i1].x);
        chk("y_lane1", int'(bus.Y_out[17:9]), tbl[e.i1].y);
        chk("z_lane1", int'(bus.Z_out[17:9]), tbl[e.i1].z);
      end
      nout++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (bus.out_valid && !bus.out_ready) begin
      chk("stall_in_ready", int'(bus.in_ready), 0);
      if (prev_stall) chk("stall_hold_x", int'(bus.X_out), prev_x);
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_x     = int'(bus.X_out);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_single(input int i0, input int i1);
    int lat;
    set_pix(i0, i1);
    bus.in_valid = 1'b1;
    step();
    chk("single_accept", int'(acc), 1);
    bus.in_valid = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!last_ov && lat < 10);
    chk("latency", lat, 3);
    step();
    chk("out_valid_drop", int'(last_ov), 0);
  endtask

  task automatic run_stream(input bit do_stall);
    int sent, t, start;
    sent = 0;
    t = 0;
    start = nout;
    first_out = -1;
    while ((sent < 10 || expq.size() > 0) && t < 100) begin
      bus.in_valid  = (sent < 10);
      set_pix(sent % 7, (sent + 3) % 7);
      bus.out_ready = !(do_stall && t >= 4 && t < 9);
      step();
      if (!do_stall && bus.in_valid) chk("stream_in_ready", int'(rdy_seen), 1);
      if (acc) sent++;
      t++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count", nout - start, 10);
    chk("stream_queue_empty", expq.size(), 0);
    if (!do_stall) chk("stream_contiguous", last_out - first_out + 1, 10);
  endtask

  initial begin
    int seen;
    tbl[0] = '{0,   0,   0,   0,   0,   0};
    tbl[1] = '{255, 0,   0,   105, 54,  5};
    tbl[2] = '{0,   255, 0,   92,  181, 31};
    tbl[3] = '{0,   0,   255, 46,  18,  242};
    tbl[4] = '{255, 255, 255, 242, 253, Z_WHITE};
    tbl[5] = '{128, 128, 128, 122, 127, 139};
    tbl[6] = '{2,   0,   0,   1,   0,   0};
    prev_stall    = 1'b0;
    prev_x        = 0;
    Reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_pix(0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_x_out", int'(bus.X_out), 0);
    chk("reset_z_out", int'(bus.Z_out), 0);
    Reset_n = 1'b1;
    step();
    chk("ready_after_reset", int'(rdy_seen), 1);

    run_single(0, 0);
    run_single(1, 0);
    run_single(4, 5);
    run_single(6, 2);
    run_single(3, 1);

    run_stream(1'b0);
    run_stream(1'b1);

    // Two beats in flight, then asynchronous reset must discard them
    bus.in_valid = 1'b1;
    set_pix(4, 1);
    step();
    set_pix(1, 4);
    step();
    bus.in_valid = 1'b0;
    #2;
    Reset_n = 1'b0;
    expq.delete();
    #1;
    chk("midreset_out_valid", int'(bus.out_valid), 0);
    repeat (2) @(posedge clk);
    #3;
    Reset_n = 1'b1;
    seen = 0;
    repeat (6) begin
      step();
      if (last_ov) seen++;
    end
    chk("discarded_outputs", seen, 0);
    run_single(4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule

`default_nettype wire
